// File: rtl/video_mode_sequencer.sv
// Video mode-change sequencer: frame-aligned blank, PLL reconfigure, lock/settle, unblank.
// Optional MODE_SEQ_LOCK_RECOVERY_EN: re-run the PLL sequence on sustained lock loss in IDLE.
module video_mode_sequencer #(
  parameter int unsigned MODE_BITS     = 3,
  parameter int unsigned NUM_MODES     = 5,
  parameter int unsigned DEFAULT_MODE  = 0,
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned LOCK_STABLE   = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1048576,
  parameter int unsigned FRAME_TIMEOUT = 2097152
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_mode_req,
  input  logic [MODE_BITS-1:0] i_mode_sel,
  output logic                 o_mode_busy,
  output logic                 o_mode_ack,
  output logic                 o_mode_err,
  output logic [MODE_BITS-1:0] o_active_mode,
  input  logic                 i_vsync,
  input  logic                 i_vsync_pol,
  output logic                 o_pll_cfg_start,
  output logic [MODE_BITS-1:0] o_pll_cfg_mode,
  input  logic                 i_pll_cfg_busy,
  input  logic                 i_pll_locked,
  output logic                 o_video_reset,
  output logic                 o_blank
);

  typedef enum logic [3:0] {
    StInit, StIdle, StWaitFrame, StBlank, StPllStart,
    StPllWait, StLockWait, StSettle, StDone, StError
  } state_e;

  localparam logic [MODE_BITS-1:0] DefMode    = MODE_BITS'(DEFAULT_MODE);
  localparam logic [20:0]          FrameLim   = 21'(FRAME_TIMEOUT - 1);
  localparam logic [20:0]          LockLim    = 21'(LOCK_TIMEOUT - 1);
  localparam logic [15:0]          StableLast = 16'(LOCK_STABLE - 1);
  localparam logic [15:0]          SettleLast = 16'(SETTLE_FRAMES - 1);

  state_e               r_state, w_state_d;
  logic [MODE_BITS-1:0] r_target, w_target_d;
  logic [15:0]          r_aux, w_aux_d;
  logic [20:0]          r_cnt, w_cnt_d;
  logic                 w_cnt_clr;
  logic                 r_quiet, w_quiet_d;
  logic [1:0]           r_vs_sync, r_lk_sync;
  logic                 r_vs_last;
  logic                 w_vs_edge, w_locked;
  logic                 r_busy, r_ack, r_err, r_blank, r_vreset, r_start;
  logic [MODE_BITS-1:0] r_active, r_cfg_mode;
  logic                 w_busy_d, w_ack_d, w_err_d, w_blank_d, w_vreset_d, w_start_d;
  logic [MODE_BITS-1:0] w_active_d, w_cfg_mode_d;
`ifdef MODE_SEQ_LOCK_RECOVERY_EN
  logic [1:0]           r_lost;
`endif

  assign w_locked  = r_lk_sync[1];
  assign w_vs_edge = (r_vs_sync[1] == i_vsync_pol) && (r_vs_last != i_vsync_pol);
  assign w_cnt_d   = w_cnt_clr ? '0 : ((r_cnt == '1) ? r_cnt : r_cnt + 21'd1);

  always_comb begin
    w_state_d    = r_state;
    w_target_d   = r_target;
    w_aux_d      = r_aux;
    w_cnt_clr    = 1'b0;
    w_quiet_d    = r_quiet;
    w_busy_d     = r_busy;
    w_ack_d      = 1'b0;
    w_err_d      = r_err;
    w_active_d   = r_active;
    w_blank_d    = r_blank;
    w_vreset_d   = r_vreset;
    w_start_d    = 1'b0;
    w_cfg_mode_d = r_cfg_mode;
    unique case (r_state)
      StInit: begin
        w_target_d = DefMode;
        w_quiet_d  = 1'b1;
        w_state_d  = StPllStart;
      end
      StIdle: begin
        if (i_mode_req) begin
          if (32'(i_mode_sel) >= NUM_MODES) begin
            w_err_d = 1'b1;
          end else if (i_mode_sel == r_active && !r_err) begin
            w_ack_d = 1'b1;
          end else begin
            w_target_d = i_mode_sel;
            w_err_d    = 1'b0;
            w_busy_d   = 1'b1;
            w_quiet_d  = 1'b0;
            w_state_d  = StWaitFrame;
          end
        end
`ifdef MODE_SEQ_LOCK_RECOVERY_EN
        else if (!w_locked && r_lost == 2'd3) begin
          w_blank_d  = 1'b1;
          w_vreset_d = 1'b1;
          w_busy_d   = 1'b1;
          w_target_d = r_active;
          w_quiet_d  = 1'b1;
          w_state_d  = StPllStart;
        end
`endif
      end
      StWaitFrame: begin
        if (w_vs_edge || r_cnt >= FrameLim) begin
          w_blank_d = 1'b1;
          w_state_d = StBlank;
        end
      end
      StBlank: begin
        // Four blanked cycles before the generator is put into reset
        if (r_aux == 16'd3) begin
          w_vreset_d = 1'b1;
          w_state_d  = StPllStart;
        end else begin
          w_aux_d = r_aux + 16'd1;
        end
      end
      StPllStart: begin
        if (!i_pll_cfg_busy) begin
          w_start_d    = 1'b1;
          w_cfg_mode_d = r_target;
          w_state_d    = StPllWait;
        end
      end
      StPllWait: begin
        if (r_aux < 16'd2) w_aux_d = r_aux + 16'd1;
        else if (!i_pll_cfg_busy) w_state_d = StLockWait;
      end
      StLockWait: begin
        if (w_locked && r_aux == StableLast) begin
          w_vreset_d = 1'b0;
          w_state_d  = StSettle;
        end else if (r_cnt >= LockLim) begin
          w_state_d = StError;
        end else begin
          w_aux_d = w_locked ? r_aux + 16'd1 : '0;
        end
      end
      StSettle: begin
        if (!w_locked) begin
          w_vreset_d = 1'b1;
          w_state_d  = StLockWait;
        end else if (w_vs_edge) begin
          w_cnt_clr = 1'b1;
          if (r_aux == SettleLast) w_state_d = StDone;
          else w_aux_d = r_aux + 16'd1;
        end else if (r_cnt >= FrameLim) begin
          w_state_d = StError;
        end
      end
      StDone: begin
        w_ack_d    = !r_quiet;
        w_busy_d   = 1'b0;
        w_blank_d  = 1'b0;
        w_active_d = r_target;
        w_state_d  = StIdle;
      end
      StError: begin
        w_err_d    = 1'b1;
        w_active_d = r_target;
        w_blank_d  = 1'b1;
        w_vreset_d = 1'b1;
        w_busy_d   = 1'b0;
        w_state_d  = StIdle;
      end
      default: w_state_d = StInit;
    endcase
    if (w_state_d != r_state) begin
      w_aux_d   = '0;
      w_cnt_clr = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StInit;
      r_target   <= DefMode;
      r_aux      <= '0;
      r_cnt      <= '0;
      r_quiet    <= 1'b1;
      r_vs_sync  <= '0;
      r_vs_last  <= 1'b0;
      r_lk_sync  <= '0;
      r_busy     <= 1'b1;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_active   <= DefMode;
      r_blank    <= 1'b1;
      r_vreset   <= 1'b1;
      r_start    <= 1'b0;
      r_cfg_mode <= DefMode;
`ifdef MODE_SEQ_LOCK_RECOVERY_EN
      r_lost     <= '0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_target   <= w_target_d;
      r_aux      <= w_aux_d;
      r_cnt      <= w_cnt_d;
      r_quiet    <= w_quiet_d;
      r_vs_sync  <= {r_vs_sync[0], i_vsync};
      r_vs_last  <= r_vs_sync[1];
      r_lk_sync  <= {r_lk_sync[0], i_pll_locked};
      r_busy     <= w_busy_d;
      r_ack      <= w_ack_d;
      r_err      <= w_err_d;
      r_active   <= w_active_d;
      r_blank    <= w_blank_d;
      r_vreset   <= w_vreset_d;
      r_start    <= w_start_d;
      r_cfg_mode <= w_cfg_mode_d;
`ifdef MODE_SEQ_LOCK_RECOVERY_EN
      if (r_state == StIdle && !w_locked) r_lost <= (r_lost == 2'd3) ? r_lost : r_lost + 2'd1;
      else r_lost <= '0;
`endif
    end
  end

  assign o_mode_busy     = r_busy;
  assign o_mode_ack      = r_ack;
  assign o_mode_err      = r_err;
  assign o_active_mode   = r_active;
  assign o_blank         = r_blank;
  assign o_video_reset   = r_vreset;
  assign o_pll_cfg_start = r_start;
  assign o_pll_cfg_mode  = r_cfg_mode;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Bench for video_mode_sequencer: PLL and vsync models, transaction-level reference of mode state.
module tb_video_mode_sequencer;
  localparam int LT  = 300;
  localparam int FT  = 600;
  localparam int VSP = 60;

  logic       clk, rst, mode_req, vs_pol, vs_pulse, vsync;
  logic [2:0] mode_sel, active_mode, cfg_mode;
  logic       busy, ack, err, cfg_start, cfg_busy, pll_lk_raw, glitch, pll_locked;
  logic       vreset, blank;

  int n_vec = 0, n_err = 0, cyc = 0, n_start = 0;
  int lock_delay = 100, busy_len = 4, never_lock = 0;
  int m_active = 0, m_err = 0;

  assign vsync      = vs_pulse ? vs_pol : ~vs_pol;
  assign pll_locked = pll_lk_raw & ~glitch;

  video_mode_sequencer #(.LOCK_TIMEOUT(LT), .FRAME_TIMEOUT(FT)) dut (
    .i_clk(clk), .i_rst(rst), .i_mode_req(mode_req), .i_mode_sel(mode_sel),
    .o_mode_busy(busy), .o_mode_ack(ack), .o_mode_err(err), .o_active_mode(active_mode),
    .i_vsync(vsync), .i_vsync_pol(vs_pol), .o_pll_cfg_start(cfg_start),
    .o_pll_cfg_mode(cfg_mode), .i_pll_cfg_busy(cfg_busy), .i_pll_locked(pll_locked),
    .o_video_reset(vreset), .o_blank(blank)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end
  initial begin #800000; $display("FAIL watchdog: run did not finish"); $fatal(1); end

  initial begin
    vs_pulse = 0;
    forever begin
      repeat (VSP - 5) @(posedge clk);
      #3 vs_pulse = 1;
      repeat (5) @(posedge clk);
      #3 vs_pulse = 0;
    end
  end

  // PLL: busy for busy_len cycles after each start, then locks lock_delay cycles later
  initial begin
    cfg_busy = 0; pll_lk_raw = 1;
    forever begin
      @(posedge clk); #2;
      if (cfg_start === 1'b1) begin
        n_start++;
        pll_lk_raw = 0; cfg_busy = 1;
        repeat (busy_len) @(posedge clk);
        #2 cfg_busy = 0;
        if (never_lock == 0) begin
          repeat (lock_delay) @(posedge clk);
          #2 pll_lk_raw = 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin tick(); n++; end
    chk("idle_wait", 32'(busy), 0);
  endtask

  task automatic do_req(input int sel, input bit glitch_en);
    int s0, n, bl_cyc, vr_cyc, st_cyc, vr_fall, gl_cyc, rerise;
    bit was_unblanked, seen, glitched;
    wait_idle();
    was_unblanked = (blank === 1'b0);
    s0 = n_start;
    mode_req = 1; mode_sel = 3'(sel);
    tick();
    mode_req = 0;
    if (sel >= 5) begin
      m_err = 1;
      chk("inv_err", 32'(err), 1);
      chk("inv_busy", 32'(busy), 0);
      chk("inv_ack", 32'(ack), 0);
      repeat (10) tick();
      chk("inv_nostart", n_start, s0);
    end else if (sel == m_active && m_err == 0) begin
      chk("noop_ack", 32'(ack), 1);
      chk("noop_busy", 32'(busy), 0);
      tick();
      chk("noop_ack_end", 32'(ack), 0);
    end else begin
      chk("acc_busy", 32'(busy), 1);
      chk("acc_err", 32'(err), 0);
      m_err = 0;
      bl_cyc = -1; vr_cyc = -1; n = 0; seen = 0;
      while (n < 400 && !seen) begin
        if (n == 3) begin mode_req = 1; mode_sel = 3'((sel + 1) % 5); end
        if (n == 4) mode_req = 0;
        if (cfg_start === 1'b1) seen = 1;
        else begin
          tick(); n++;
          if (blank === 1'b1 && bl_cyc < 0) bl_cyc = cyc;
          if (vreset === 1'b1 && vr_cyc < 0) vr_cyc = cyc;
        end
      end
      mode_req = 0;
      chk("start_seen", 32'(seen), 1);
      chk("start_mode", 32'(cfg_mode), 32'(sel));
      chk("start_blank", 32'(blank), 1);
      chk("start_vreset", 32'(vreset), 1);
      if (was_unblanked) chk("blank_gap", vr_cyc - bl_cyc, 4);
      st_cyc = cyc;
      tick();
      chk("start_pulse", 32'(cfg_start), 0);
      n = 0; vr_fall = 0; gl_cyc = 0; rerise = 0; glitched = 0;
      while (busy === 1'b1 && n < LT + 800) begin
        if (glitched && gl_cyc == cyc - 1) glitch = 0;
        tick(); n++;
        if (vreset === 1'b0 && vr_fall == 0) begin
          vr_fall = cyc;
          if (glitch_en && !glitched) begin glitch = 1; glitched = 1; gl_cyc = cyc; end
        end
        if (vreset === 1'b1 && vr_fall != 0) begin rerise++; vr_fall = 0; end
      end
      glitch = 0;
      chk("done_seen", 32'(busy), 0);
      m_active = sel;
      chk("done_active", 32'(active_mode), 32'(sel));
      if (never_lock == 0) begin
        chk("done_ack", 32'(ack), 1);
        chk("done_blank", 32'(blank), 0);
        chk("done_vreset", 32'(vreset), 0);
        chk("done_err", 32'(err), 0);
        chk("settle_len", 32'((cyc - vr_fall) >= VSP), 1);
        if (glitch_en) begin
          chk("glitch_rerise", rerise, 1);
          chk("glitch_relock", 32'((cyc - gl_cyc) >= 16 + VSP), 1);
        end
      end else begin
        m_err = 1;
        chk("to_ack", 32'(ack), 0);
        chk("to_err", 32'(err), 1);
        chk("to_blank", 32'(blank), 1);
        chk("to_vreset", 32'(vreset), 1);
        chk("to_len", 32'((cyc - st_cyc) >= LT), 1);
      end
      tick();
      chk("ack_end", 32'(ack), 0);
    end
  endtask

  initial begin
    int s0, n;
    bit ack_seen;
    vs_pol = 1'($urandom_range(0, 1));
    rst = 0; mode_req = 0; mode_sel = 0; glitch = 0;
    #1 rst = 1;
    #1;
    chk("rst_blank", 32'(blank), 1);
    chk("rst_vreset", 32'(vreset), 1);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_start", 32'(cfg_start), 0);
    chk("rst_active", 32'(active_mode), 0);
    chk("rst_cfgmode", 32'(cfg_mode), 0);
    repeat (3) tick();
    rst = 0;
    ack_seen = 0; n = 0;
    while (busy !== 1'b0 && n < 2000) begin tick(); n++; if (ack === 1'b1) ack_seen = 1; end
    chk("init_done", 32'(busy), 0);
    chk("init_noack", 32'(ack_seen), 0);
    chk("init_blank", 32'(blank), 0);
    chk("init_active", 32'(active_mode), 0);
    chk("init_err", 32'(err), 0);
    chk("init_starts", n_start, 1);

    do_req(3, 0);
    do_req(7, 0);
    do_req(3, 0);
    do_req(3, 0);
    never_lock = 1;
    do_req(1, 0);
    never_lock = 0;
    do_req(1, 0);
    do_req(2, 1);
    for (int i = 0; i < 8; i++) begin
      lock_delay = $urandom_range(20, 120);
      busy_len   = $urandom_range(1, 8);
      do_req($urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a sequence
    wait_idle();
    mode_req = 1; mode_sel = 3'((m_active + 1) % 5);
    tick(); mode_req = 0;
    tick();
    rst = 1;
    #1;
    chk("mid_rst_busy", 32'(busy), 1);
    chk("mid_rst_blank", 32'(blank), 1);
    chk("mid_rst_active", 32'(active_mode), 0);
    tick(); rst = 0;
    m_active = 0; m_err = 0;
    wait_idle();
    chk("mid_rst_reinit", 32'(active_mode), 0);
    chk("mid_rst_unblank", 32'(blank), 0);

    // Four-cycle lock loss while idle
    lock_delay = 30;
    s0 = n_start;
    glitch = 1;
    repeat (4) tick();
    glitch = 0;
`ifdef MODE_SEQ_LOCK_RECOVERY_EN
    repeat (8) tick();
    chk("rec_busy", 32'(busy), 1);
    ack_seen = 0; n = 0;
    while (busy !== 1'b0 && n < 2000) begin tick(); n++; if (ack === 1'b1) ack_seen = 1; end
    chk("rec_done", 32'(busy), 0);
    chk("rec_noack", 32'(ack_seen), 0);
    chk("rec_starts", n_start, s0 + 1);
    chk("rec_mode", 32'(cfg_mode), 32'(m_active));
    chk("rec_unblank", 32'(blank), 0);
`else
    repeat (10) tick();
    chk("lossidle_busy", 32'(busy), 0);
    chk("lossidle_starts", n_start, s0);
    chk("lossidle_blank", 32'(blank), 0);
`endif
    do_req(4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/video_mode_sequencer.md
# video_mode_sequencer

Sequences video mode changes for the timing generator and pixel PLL, running on the control clock. It accepts a mode-change request and waits for a frame boundary. It then blanks the output, holds the video generator in reset and reconfigures the PLL. After confirmed lock and a settle period it releases the generator and acknowledges. It sits between the host/menu logic and the video timing generator plus PLL reconfiguration port.

## Interface
- MODE_BITS, 3, width of mode index
- NUM_MODES, 5, valid modes are 0..NUM_MODES-1
- DEFAULT_MODE, 0, mode configured after reset
- SETTLE_FRAMES, 2, vsync edges counted after lock before unblank
- LOCK_STABLE, 16, consecutive cycles pll_locked must stay high
- LOCK_TIMEOUT, 1048576, cycles allowed in lock wait
- FRAME_TIMEOUT, 2097152, cycles allowed waiting for a vsync edge
- clock  in  1  control clock
- reset  in  1  asynchronous, active-high
- mode_req  in  1  request strobe, sampled only when mode_busy=0
- mode_sel  in  MODE_BITS  requested mode, sampled with mode_req
- mode_busy  out  1  sequence in progress
- mode_ack  out  1  one-cycle pulse when requested mode is active
- mode_err  out  1  sticky; cleared on next accepted request
- active_mode  out  MODE_BITS  mode currently configured
- vsync_in  in  1  raw vsync from pixel domain (async)
- vsync_pol  in  1  active level of vsync_in
- pll_cfg_start  out  1  one-cycle reconfiguration pulse
- pll_cfg_mode  out  MODE_BITS  mode for PLL; stable from start pulse until IDLE
- pll_cfg_busy  in  1  PLL reconfig engine busy (control domain)
- pll_locked  in  1  PLL lock (async)
- video_reset  out  1  holds timing generator in reset
- blank  out  1  forces video output to black, DE low

## Operation
- vsync_in and pll_locked pass through 2-flop synchronizers. A vsync edge is the synchronized transition to the vsync_pol level.
- States: INIT, IDLE, WAIT_FRAME, BLANK, PLL_START, PLL_WAIT, LOCK_WAIT, SETTLE, DONE, ERROR.
- INIT (after reset): target=DEFAULT_MODE, go directly to PLL_START (no frame wait).
- IDLE, mode_req=1:
  - mode_sel>=NUM_MODES: mode_err=1, stay IDLE, no ack.
  - mode_sel==active_mode and mode_err=0: mode_ack one cycle later, no reconfig.
  - Otherwise: latch target, clear mode_err, mode_busy=1, go to WAIT_FRAME.
- Requests while busy are ignored, not queued.
- WAIT_FRAME: on vsync edge, or after FRAME_TIMEOUT cycles, go to BLANK.
- BLANK: blank=1, hold 4 cycles, then set video_reset=1 and go to PLL_START.
- PLL_START: pulse pll_cfg_start once pll_cfg_busy=0.
- PLL_WAIT: skip 2 guard cycles, then wait for pll_cfg_busy=0.
- LOCK_WAIT: needs LOCK_STABLE consecutive locked cycles; any low cycle restarts the count. Exceeding LOCK_TIMEOUT cycles goes to ERROR.
- SETTLE: video_reset=0; count SETTLE_FRAMES vsync edges.
  - Lock loss: video_reset=1, return to LOCK_WAIT with a fresh timeout.
  - FRAME_TIMEOUT with no edge: go to ERROR.
- DONE (1 cycle): active_mode=target, blank=0, mode_ack=1, mode_busy=0, go to IDLE.
- ERROR: mode_err=1, active_mode=target, blank=1, video_reset=1, mode_busy=0, go to IDLE. Outputs stay blanked until a later successful sequence.

## Timing
- Reset values: blank=1, video_reset=1, mode_busy=1, mode_ack=0, mode_err=0, pll_cfg_start=0, active_mode=pll_cfg_mode=DEFAULT_MODE.
- Reset mid-sequence aborts immediately to reset values, then re-runs INIT.
- All outputs are registered.
- mode_busy rises the cycle after an accepted mode_req.
- vsync/lock latency is 2 cycles of synchronizer plus 1 registered cycle.
- blank rises before video_reset (4-cycle gap). video_reset falls at least SETTLE_FRAMES frames before blank falls.
- mode_ack and the mode_busy fall occur in the same cycle.
- Timeout counters are 21 bits, saturate, and clear on every state entry.

## Configuration
- MODE_SEQ_LOCK_RECOVERY_EN defined: in IDLE, 4 consecutive synchronized pll_locked=0 cycles set blank=1 and video_reset=1, and re-run from PLL_START for active_mode. mode_busy=1 during recovery; mode_ack is not pulsed on completion.
- Undefined: lock loss in IDLE is ignored.

## Test plan
- Reset release, PLL locks 100 cycles after cfg_busy falls, 2 vsyncs -> ack low, blank falls, active_mode=0, mode_err=0.
- IDLE, req mode_sel=3 -> busy next cycle; cfg_start pulses after vsync edge plus 4 blank cycles with pll_cfg_mode=3; ack after 2 settle vsyncs; active_mode=3.
- req mode_sel=7 (NUM_MODES=5) -> mode_err=1, busy stays 0, no cfg_start.
- pll_locked never rises -> ERROR after LOCK_TIMEOUT; mode_err=1, blank=1, video_reset=1, busy=0.
- Lock drops for 1 cycle in SETTLE -> video_reset reasserts, LOCK_WAIT re-entered, ack only after 16 stable cycles plus 2 vsyncs.
- Second req during busy -> ignored. With MODE_SEQ_LOCK_RECOVERY_EN, a 4-cycle lock loss in IDLE -> new cfg_start for active_mode, no ack.
